alsu_pipe: RTL and testbench
============================

ALSU_PIPE -- requirements
Module: alsu_pipe

Interface
REQ-001 Parameter WIDTH, default 3: signed operand width, legal 2..16.
REQ-002 Parameter INPUT_PRIORITY, default "A": operand chosen when both bypass or both red_op flags are set.
REQ-003 Parameter FULL_ADDER, default "ON": "ON" adds cin in ADD; "OFF" ignores cin.
REQ-004 Parameter LED_W, default 16: width of leds.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  operation bundle present.
REQ-008 in_ready  out  1  block can accept a bundle.
REQ-009 A, B  in  WIDTH  signed operands.
REQ-010 opcode  in  3  operation select.
REQ-011 cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  operation modifiers.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out  out  2*WIDTH  signed result.
REQ-015 leds  out  LED_W  invalid-operation indicator.
REQ-016 err_cnt  out  8  count of invalid operations.

Function
REQ-017 Two stages: S1 registers the accepted bundle; S2 registers the result; result appears 2 cycles after acceptance with no stall.
REQ-018 Bundle accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-019 S2 loads when S1 valid && (!out_valid || out_ready); in_ready = !S1_valid || S2 loads; full throughput of 1 op/cycle.
REQ-020 While out_valid && !out_ready: out, out_valid, leds, err_cnt held stable; no bundle lost or reordered.
REQ-021 Invalid = opcode 6/7, or (red_op_A || red_op_B) with opcode not 0/1.
REQ-022 Priority on S2 load: invalid > bypass > opcode.
REQ-023 Invalid: out = 0, leds inverted, err_cnt +1 saturating at 255; valid op: leds = 0, err_cnt held.
REQ-024 Bypass: both set picks INPUT_PRIORITY operand; else set one; sign-extended to 2*WIDTH.
REQ-025 Opcode 0 AND / 1 OR: red_op selects reduction of one operand (both set -> INPUT_PRIORITY), 1-bit result zero-extended; else bitwise A op B sign-extended.
REQ-026 Opcode 2 ADD: sign-extended A + B (+ cin when FULL_ADDER "ON"); never overflows 2*WIDTH.
REQ-027 Opcode 3 MUL: full signed A*B, 2*WIDTH bits.
REQ-028 Opcode 4 SHIFT: direction 1 -> {out[2W-2:0], serial_in}; 0 -> {serial_in, out[2W-1:1]}, using current S2 out.
REQ-029 Opcode 5 ROTATE: direction 1 rotate left by 1; 0 rotate right by 1, using current S2 out.
REQ-030 Back-to-back SHIFT/ROTATE chain on each previous result in order of issue.

Reset
REQ-031 rst clears S1, S2: out = 0, out_valid = 0, leds = 0, err_cnt = 0; in_ready = 1 after release.
REQ-032 In-flight bundles during rst are discarded; no result produced for them.

Structure
REQ-033 Package alsu_pkg holds opcode enum (OP_AND..OP_ROT, OP_INV6, OP_INV7) and operation bundle struct typedef.
REQ-034 Combinational sub-module alsu_op_unit computes result and invalid flag from S1 contents and current out.
REQ-035 No combinational path from in_valid to in_ready; out_ready -> in_ready path permitted.

Verification
REQ-036 WIDTH=3, ADD A=3 B=2 cin=1 -> out=6 two cycles later; A=-4 B=-4 cin=0 -> out=-8 (6'b111000).
REQ-037 MUL A=-4 B=3 -> out=-12 (6'b110100); bypass_A=bypass_B=1 A=-2 B=1 -> out=-2.
REQ-038 Opcode 6 three back-to-back, out_ready=1 -> leds FFFF, 0000, FFFF; out=0; err_cnt=3; then AND valid -> leds 0000.
REQ-039 out_ready=0, three bundles offered -> two accepted, in_ready=0, out held; out_ready=1 -> three results in order.
REQ-040 out=6'b000110, SHIFT direction=1 serial_in=1 -> 6'b001101; then ROTATE direction=0 -> 6'b100110.
REQ-041 rst asserted with both stages valid -> out=0, out_valid=0, leds=0, err_cnt=0 same cycle; no stale result after release.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared types for the ALSU pipeline: opcode encoding, per-operation control bundle,
// and the invalid-operation rule.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_ADD   = 3'd2,
        OP_MUL   = 3'd3,
        OP_SHIFT = 3'd4,
        OP_ROT   = 3'd5,
        OP_INV6  = 3'd6,
        OP_INV7  = 3'd7
    } opcode_e;

    // Operands are carried beside this bundle because their width is per-instance.
    typedef struct packed {
        opcode_e opcode;
        logic    cin;
        logic    serial_in;
        logic    direction;
        logic    red_op_a;
        logic    red_op_b;
        logic    bypass_a;
        logic    bypass_b;
    } alsu_bundle_t;

    function automatic logic is_invalid(input opcode_e op, input logic red_a, input logic red_b);
        return (op == OP_INV6) || (op == OP_INV7) ||
               ((red_a || red_b) && !((op == OP_AND) || (op == OP_OR)));
    endfunction

endpackage

// File: rtl/alsu_pipe_if.sv
// Operation/result handshake bundle for alsu_pipe; master drives operations, slave is the ALSU.
interface alsu_pipe_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   A;
    logic signed [WIDTH-1:0]   B;
    logic [2:0]                opcode;
    logic                      cin;
    logic                      serial_in;
    logic                      direction;
    logic                      red_op_A;
    logic                      red_op_B;
    logic                      bypass_A;
    logic                      bypass_B;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] out;
    logic [LED_W-1:0]          leds;
    logic [7:0]                err_cnt;

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
        input  in_ready, out_valid, out, leds, err_cnt
    );

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
        output in_ready, out_valid, out, leds, err_cnt
    );
endinterface

// File: rtl/alsu_op_unit.sv
// Combinational ALSU datapath: result and invalid flag from the S1 operation
// and the currently registered output (used by SHIFT/ROTATE).
module alsu_op_unit
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON"
) (
    input  alsu_bundle_t              bundle,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [2*WIDTH-1:0] cur_out,
    output logic signed [2*WIDTH-1:0] result,
    output logic                      invalid
);
    localparam int OW      = 2 * WIDTH;
    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    logic signed [OW-1:0] a_ext;
    logic signed [OW-1:0] b_ext;
    logic                 red_pick_a;
    logic                 red_bit;

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

    // With both reduction flags set the priority operand wins.
    assign red_pick_a = bundle.red_op_a && (!bundle.red_op_b || PRIO_A);

    always_comb begin
        result  = '0;
        red_bit = 1'b0;
        invalid = is_invalid(bundle.opcode, bundle.red_op_a, bundle.red_op_b);

        if (invalid) begin
            result = '0;
        end else if (bundle.bypass_a || bundle.bypass_b) begin
            if (bundle.bypass_a && bundle.bypass_b)
                result = PRIO_A ? a_ext : b_ext;
            else if (bundle.bypass_a)
                result = a_ext;
            else
                result = b_ext;
        end else begin
            case (bundle.opcode)
                OP_AND: begin
                    if (bundle.red_op_a || bundle.red_op_b) begin
                        red_bit = red_pick_a ? (&a) : (&b);
                        result  = {{(OW-1){1'b0}}, red_bit};
                    end else begin
                        result = a_ext & b_ext;
                    end
                end
                OP_OR: begin
                    if (bundle.red_op_a || bundle.red_op_b) begin
                        red_bit = red_pick_a ? (|a) : (|b);
                        result  = {{(OW-1){1'b0}}, red_bit};
                    end else begin
                        result = a_ext | b_ext;
                    end
                end
                OP_ADD:
                    result = a_ext + b_ext + {{(OW-1){1'b0}}, (ADD_CIN && bundle.cin)};
                OP_MUL:
                    result = a_ext * b_ext;
                OP_SHIFT:
                    result = bundle.direction ? {cur_out[OW-2:0], bundle.serial_in}
                                              : {bundle.serial_in, cur_out[OW-1:1]};
                OP_ROT:
                    result = bundle.direction ? {cur_out[OW-2:0], cur_out[OW-1]}
                                              : {cur_out[0], cur_out[OW-1:1]};
                default:
                    result = '0;
            endcase
        end
    end
endmodule

// File: rtl/alsu_pipe.sv
// Two-stage ALSU with valid/ready on both sides: S1 holds the accepted operation,
// S2 holds the result, LED indicator and saturating invalid-operation counter.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int LED_W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    alsu_pipe_if.slave   bus
);
    localparam int OW = 2 * WIDTH;

    logic                    s1_valid;
    alsu_bundle_t            s1_bundle;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    alsu_bundle_t            in_bundle;

    logic                    out_valid_q;
    logic signed [OW-1:0]    out_q;
    logic [LED_W-1:0]        leds_q;
    logic [7:0]              err_q;

    logic                    s2_load;
    logic signed [OW-1:0]    op_result;
    logic                    op_invalid;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign s2_load      = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;

    always_comb begin
        in_bundle           = '0;
        in_bundle.opcode    = opcode_e'(bus.opcode);
        in_bundle.cin       = bus.cin;
        in_bundle.serial_in = bus.serial_in;
        in_bundle.direction = bus.direction;
        in_bundle.red_op_a  = bus.red_op_A;
        in_bundle.red_op_b  = bus.red_op_B;
        in_bundle.bypass_a  = bus.bypass_A;
        in_bundle.bypass_b  = bus.bypass_B;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bundle <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_bundle <= in_bundle;
                s1_a      <= bus.A;
                s1_b      <= bus.B;
            end
        end
    end

    alsu_op_unit #(
        .WIDTH          (WIDTH),
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_op_unit (
        .bundle  (s1_bundle),
        .a       (s1_a),
        .b       (s1_b),
        .cur_out (out_q),
        .result  (op_result),
        .invalid (op_invalid)
    );

    // out_q keeps its value after consumption so SHIFT/ROTATE chain on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            leds_q      <= '0;
            err_q       <= '0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            out_q       <= op_result;
            if (op_invalid) begin
                leds_q <= ~leds_q;
                if (err_q != 8'hFF)
                    err_q <= err_q + 8'd1;
            end else begin
                leds_q <= '0;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.leds      = leds_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe (WIDTH=3): directed operations push expected results,
// an independent monitor pops and compares each consumed result.
module tb_alsu_pipe;
    import alsu_pkg::*;

    localparam int W  = 3;
    localparam int OW = 6;
    localparam int LW = 16;

    localparam logic [6:0] M_NONE = 7'b0000000;
    localparam logic [6:0] M_CIN  = 7'b1000000;
    localparam logic [6:0] M_SER  = 7'b0100000;
    localparam logic [6:0] M_DIR  = 7'b0010000;
    localparam logic [6:0] M_RA   = 7'b0001000;
    localparam logic [6:0] M_RB   = 7'b0000100;
    localparam logic [6:0] M_BA   = 7'b0000010;
    localparam logic [6:0] M_BB   = 7'b0000001;

    typedef struct {
        logic [OW-1:0] out;
        logic [LW-1:0] leds;
        logic [7:0]    err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alsu_pipe_if #(.WIDTH(W), .LED_W(LW)) bus ();

    alsu_pipe #(
        .WIDTH          (W),
        .INPUT_PRIORITY ("A"),
        .FULL_ADDER     ("ON"),
        .LED_W          (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [6:0] mods, input logic [OW-1:0] e_out,
                        input logic [LW-1:0] e_leds, input logic [7:0] e_err);
        exp_t e;
        bus.opcode = op;
        bus.A      = a;
        bus.B      = b;
        {bus.cin, bus.serial_in, bus.direction, bus.red_op_A, bus.red_op_B,
         bus.bypass_A, bus.bypass_B} = mods;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.out  = e_out;
                e.leds = e_leds;
                e.err  = e_err;
                sb.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: in_ready stayed 0 for opcode %0d", op);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result: got out=%b with none expected", bus.out);
                end else begin
                    e = sb.pop_front();
                    if (bus.out !== e.out || bus.leds !== e.leds || bus.err_cnt !== e.err) begin
                        fails++;
                        $display("FAIL result: got out=%b leds=%h err=%0d expected out=%b leds=%h err=%0d",
                                 bus.out, bus.leds, bus.err_cnt, e.out, e.leds, e.err);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.opcode = '0;
        {bus.cin, bus.serial_in, bus.direction, bus.red_op_A, bus.red_op_B,
         bus.bypass_A, bus.bypass_B} = M_NONE;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_leds", bus.leds, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Arithmetic, logic, bypass
        send(3'd2, 3'b011, 3'b010, M_CIN,       6'b000110, 16'h0000, 8'd0); // 3+2+1
        send(3'd2, 3'b100, 3'b100, M_NONE,      6'b111000, 16'h0000, 8'd0); // -4-4
        send(3'd3, 3'b100, 3'b011, M_NONE,      6'b110100, 16'h0000, 8'd0); // -4*3
        send(3'd2, 3'b110, 3'b001, M_BA | M_BB, 6'b111110, 16'h0000, 8'd0); // bypass A=-2
        send(3'd3, 3'b010, 3'b101, M_BB,        6'b111101, 16'h0000, 8'd0); // bypass B=-3
        send(3'd0, 3'b011, 3'b110, M_NONE,      6'b000010, 16'h0000, 8'd0); // 011&110
        send(3'd1, 3'b000, 3'b111, M_RB,        6'b000001, 16'h0000, 8'd0); // |B
        send(3'd0, 3'b111, 3'b000, M_RA | M_RB, 6'b000001, 16'h0000, 8'd0); // &A wins
        send(3'd1, 3'b001, 3'b100, M_NONE,      6'b111101, 16'h0000, 8'd0); // 001|100
        send(3'd2, 3'b011, 3'b011, M_CIN,       6'b000111, 16'h0000, 8'd0); // 3+3+1
        send(3'd2, 3'b100, 3'b100, M_CIN,       6'b111001, 16'h0000, 8'd0); // -4-4+1

        // Shift/rotate chain issued back-to-back
        send(3'd2, 3'b011, 3'b010, M_CIN,         6'b000110, 16'h0000, 8'd0);
        send(3'd4, 3'b000, 3'b000, M_DIR | M_SER, 6'b001101, 16'h0000, 8'd0);
        send(3'd5, 3'b000, 3'b000, M_NONE,        6'b100110, 16'h0000, 8'd0);
        send(3'd4, 3'b000, 3'b000, M_SER,         6'b110011, 16'h0000, 8'd0);
        send(3'd5, 3'b000, 3'b000, M_DIR,         6'b100111, 16'h0000, 8'd0);

        // Invalid operations
        send(3'd6, 3'b001, 3'b001, M_NONE,      6'b000000, 16'hFFFF, 8'd1);
        send(3'd6, 3'b001, 3'b001, M_NONE,      6'b000000, 16'h0000, 8'd2);
        send(3'd6, 3'b001, 3'b001, M_NONE,      6'b000000, 16'hFFFF, 8'd3);
        send(3'd0, 3'b011, 3'b011, M_NONE,      6'b000011, 16'h0000, 8'd3);
        send(3'd2, 3'b001, 3'b001, M_RA,        6'b000000, 16'hFFFF, 8'd4);
        send(3'd7, 3'b001, 3'b001, M_BA,        6'b000000, 16'h0000, 8'd5);
        send(3'd4, 3'b000, 3'b000, M_BA | M_RB, 6'b000000, 16'hFFFF, 8'd6);
        wait_drain();

        // Backpressure: two accepted, third waits, output held
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(3'd2, 3'b001, 3'b001, M_NONE, 6'b000010, 16'h0000, 8'd6);
        send(3'd3, 3'b010, 3'b011, M_NONE, 6'b000110, 16'h0000, 8'd6);
        fork
            send(3'd2, 3'b111, 3'b111, M_NONE, 6'b111110, 16'h0000, 8'd6);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_out_held", bus.out, 6'b000010);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with both stages occupied
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(3'd6, 3'b000, 3'b000, M_NONE, 6'b000000, 16'hFFFF, 8'd7);
        send(3'd6, 3'b000, 3'b000, M_NONE, 6'b000000, 16'h0000, 8'd8);
        check("pre_rst_leds", bus.leds, 16'hFFFF);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out", bus.out, 0);
        check("mid_rst_leds", bus.leds, 0);
        check("mid_rst_err_cnt", bus.err_cnt, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(3'd2, 3'b001, 3'b001, M_NONE, 6'b000010, 16'h0000, 8'd0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
